// File: rtl/bitslam_mixer_if.sv
// Pin-side bus of the bitslam mixer: 6-bit address/data strobe bus in,
// mixed audio sample and raw per-voice source bits out.
interface bitslam_mixer_if #(
  parameter int NUM_VOICES = 2,
  parameter int VOL_WIDTH  = 4
);
  localparam int OUT_WIDTH = VOL_WIDTH + $clog2(NUM_VOICES);

  logic                  addr_data_sel;
  logic [5:0]            addr_data;
  logic [OUT_WIDTH-1:0]  audio_out;
  logic [NUM_VOICES-1:0] voice_bits;

  modport master (
    output addr_data_sel, addr_data,
    input  audio_out, voice_bits
  );

  modport slave (
    input  addr_data_sel, addr_data,
    output audio_out, voice_bits
  );
endinterface

// File: rtl/bitslam_mixer.sv
// bitslam_mixer: NUM_VOICES independent noise/square voices, each with a
// clock divider, tap-configurable LFSR, square flop, volume and enable,
// summed into one registered audio sample.
module bitslam_mixer #(
  parameter int NUM_VOICES = 2,
  parameter int LFSR_WIDTH = 10,
  parameter int VOL_WIDTH  = 4
) (
  input  logic            clk,
  input  logic            rst,
  bitslam_mixer_if.slave  bus
);
  localparam int OUT_WIDTH = VOL_WIDTH + $clog2(NUM_VOICES);

  logic [5:0]            addr_q, addr_d;
  logic [5:0]            div_max_q [NUM_VOICES];
  logic [5:0]            div_max_d [NUM_VOICES];
  logic [3:0]            tap_q     [NUM_VOICES];
  logic [3:0]            tap_d     [NUM_VOICES];
  logic [VOL_WIDTH-1:0]  vol_q     [NUM_VOICES];
  logic [VOL_WIDTH-1:0]  vol_d     [NUM_VOICES];
  logic [NUM_VOICES-1:0] en_q, en_d;
  logic [NUM_VOICES-1:0] mode_q, mode_d;
  logic [5:0]            cnt_q     [NUM_VOICES];
  logic [5:0]            cnt_d     [NUM_VOICES];
  logic [LFSR_WIDTH-1:0] lfsr_q    [NUM_VOICES];
  logic [LFSR_WIDTH-1:0] lfsr_d    [NUM_VOICES];
  logic [NUM_VOICES-1:0] sq_q, sq_d;
  logic [NUM_VOICES-1:0] voice_bits_q, voice_bits_d;
  logic [OUT_WIDTH-1:0]  audio_out_q, audio_out_d;

  logic [3:0]            wr_voice;
  logic [NUM_VOICES-1:0] tick;
  logic [NUM_VOICES-1:0] fb;
  logic [NUM_VOICES-1:0] src;

  assign wr_voice = addr_q[5:2];

  // Bus decode: latch address, or write the held address's voice register.
  always_comb begin
    addr_d    = addr_q;
    div_max_d = div_max_q;
    tap_d     = tap_q;
    vol_d     = vol_q;
    en_d      = en_q;
    mode_d    = mode_q;
    if (!bus.addr_data_sel) begin
      addr_d = bus.addr_data;
    end else begin
      // Out-of-range voice numbers match no loop index, so they write nothing.
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        if (wr_voice == 4'(i)) begin
          case (addr_q[1:0])
            2'd0: div_max_d[i] = bus.addr_data;
            2'd1: tap_d[i]     = bus.addr_data[3:0];
            2'd2: vol_d[i]     = bus.addr_data[VOL_WIDTH-1:0];
            default: begin
              en_d[i]   = bus.addr_data[0];
              mode_d[i] = bus.addr_data[1];
            end
          endcase
        end
      end
    end
  end

  // Per-voice divider and source advance; dividers run regardless of enable.
  always_comb begin
    tick   = '0;
    fb     = '0;
    src    = '0;
    cnt_d  = cnt_q;
    lfsr_d = lfsr_q;
    sq_d   = sq_q;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      tick[i] = (cnt_q[i] >= div_max_q[i]);
      fb[i]   = (tap_q[i][0] & lfsr_q[i][1]) ^
                (tap_q[i][1] & lfsr_q[i][4]) ^
                (tap_q[i][2] & lfsr_q[i][6]) ^
                (tap_q[i][3] & lfsr_q[i][LFSR_WIDTH-1]);
      src[i]  = mode_q[i] ? sq_q[i] : lfsr_q[i][0];
      cnt_d[i] = tick[i] ? '0 : cnt_q[i] + 6'd1;
      if (tick[i]) begin
        if (mode_q[i]) begin
          sq_d[i] = ~sq_q[i];
        end else if (lfsr_q[i] == '0) begin
          lfsr_d[i] = LFSR_WIDTH'(1);
        end else begin
          lfsr_d[i] = {lfsr_q[i][LFSR_WIDTH-2:0], fb[i]};
        end
      end
    end
  end

  // Mixer: sum volumes of enabled voices whose source bit is high.
  always_comb begin
    audio_out_d  = '0;
    voice_bits_d = src;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (en_q[i] && src[i]) begin
        audio_out_d = audio_out_d + OUT_WIDTH'(vol_q[i]);
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      en_q         <= '0;
      mode_q       <= '0;
      sq_q         <= '0;
      voice_bits_q <= '0;
      audio_out_q  <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        div_max_q[i] <= '0;
        tap_q[i]     <= '0;
        vol_q[i]     <= '0;
        cnt_q[i]     <= '0;
        lfsr_q[i]    <= LFSR_WIDTH'(1);
      end
    end else begin
      addr_q       <= addr_d;
      en_q         <= en_d;
      mode_q       <= mode_d;
      sq_q         <= sq_d;
      voice_bits_q <= voice_bits_d;
      audio_out_q  <= audio_out_d;
      div_max_q    <= div_max_d;
      tap_q        <= tap_d;
      vol_q        <= vol_d;
      cnt_q        <= cnt_d;
      lfsr_q       <= lfsr_d;
    end
  end

  assign bus.audio_out  = audio_out_q;
  assign bus.voice_bits = voice_bits_q;
endmodule

// File: doc/bitslam_mixer.md
Name: bitslam_mixer

Overview:
- Multi-voice successor to the single-voice bitslam noise generator.
- NUM_VOICES independent voices, each with a clock divider, a tap-configurable LFSR or square-wave source, a volume register and an enable bit.
- Voices are summed into one registered multi-bit audio sample.
- Configured through the existing 6-bit address/data strobe bus; sits directly behind the chip pins.

Parameters:
- NUM_VOICES, 2, number of voices; legal range 1..16.
- LFSR_WIDTH, 10, per-voice LFSR length; legal range 7..16.
- VOL_WIDTH, 4, per-voice volume width; legal range 1..6.
- OUT_WIDTH (localparam), VOL_WIDTH + clog2(NUM_VOICES) (minimum VOL_WIDTH), mixed sample width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- addr_data_sel  in  1  0 = bus carries address, 1 = bus carries data.
- addr_data  in  6  address or data value.
- audio_out  out  OUT_WIDTH  registered sum of active voice volumes.
- voice_bits  out  NUM_VOICES  raw per-voice source bit (bit i = voice i), registered.

Behaviour:
Reset (async, immediate)
- addr = 0. All divider, tap, volume and control registers = 0.
- Divide counters = 0. Every LFSR = 1. Square flops = 0.
- audio_out = 0. voice_bits = 0.

Bus
- addr_data_sel = 0: addr <= addr_data every clock.
- addr_data_sel = 1: write addr_data into the register selected by the held addr. addr is unchanged.
- Decode: voice = addr[5:2], reg = addr[1:0].
- voice >= NUM_VOICES: write ignored, no side effects.
- Per-voice registers:
  - reg 0: div_max[5:0].
  - reg 1: tap_mask[3:0]; enables taps at LFSR bits 1, 4, 6, LFSR_WIDTH-1; upper data bits ignored.
  - reg 2: volume[VOL_WIDTH-1:0]; upper bits ignored.
  - reg 3: ctrl; bit0 = enable, bit1 = mode (0 noise, 1 square); upper bits ignored.
- A written value is visible to the voice logic from the cycle after the write edge.

Divider (per voice, runs regardless of enable)
- tick = (count >= div_max).
- On tick: count <= 0; otherwise count <= count + 1.
- Tick period is div_max + 1 cycles; div_max = 0 ticks every cycle.
- If div_max is lowered below the current count, tick asserts on the next cycle and the counter restarts.

Source (advances only on tick)
- Noise mode:
  - lfsr == 0: lfsr <= 1.
  - Otherwise: lfsr <= {lfsr[LFSR_WIDTH-2:0], XOR of masked taps}.
  - tap_mask = 0 shifts in 0s; the register reaches 0, then reloads 1. No lock-up.
- Square mode: sq <= ~sq. The LFSR holds its value.
- Source bit = lfsr[0] in noise mode, sq in square mode.
- A mode change takes effect on the next cycle; neither source is reset by it.

Mixer
- voice_bits[i] <= source bit of voice i, every clock.
- audio_out <= sum over i of (enable_i & source_bit_i) ? volume_i : 0.
- Width is OUT_WIDTH; no saturation is possible.
- Latency: a tick updates the source at edge N. voice_bits and audio_out reflect it at edge N+1.
- A disabled voice contributes 0 but keeps advancing.

Simultaneous events
- A write to div_max on a tick edge: the tick uses the old value.
- Reset asserted mid-operation: all state returns to reset values immediately. The first tick after release occurs with div_max = 0, so on the first clock.

Test Plan:
- Reset, then no writes -> audio_out = 0 always. voice_bits[0] shows LFSR bit0 = 1 after the first edges, then 0s, because the tap mask is 0 (the LFSR shifts 1 out, reaches 0, reloads 1).
- Voice 0: div_max = 3, tap_mask = 0xF, volume = 0xF, ctrl = 1 (noise, 10-bit) -> voice_bits[0] matches a software LFSR stepped every 4 clocks. The sequence has period 1023 when the masked taps form a maximal polynomial; the bench checks against its model. audio_out = 15 when the bit is 1, else 0.
- Voice 1: ctrl = 3 (square), div_max = 0, volume = 5 -> voice_bits[1] toggles every clock. audio_out alternates 0/5 with a one-cycle lag.
- Both voices in square mode, div_max = 0, volume = 15 each, ctrl = 3 for both -> audio_out reaches 30 (OUT_WIDTH = 5) with no overflow.
- Write to address 0x08 (voice 2 with NUM_VOICES = 2) -> no register in voices 0 or 1 changes. Also: lowering div_max from 40 to 2 while count = 20 -> tick on the next cycle, then a period of 3.
- Assert rst mid-stream with audio_out nonzero -> audio_out = 0 and voice_bits = 0 immediately, without a clock edge. All registers read back as reset values.
